// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog. rst_o exists only when
// CLK_DIV_PROG_RST_OUT_EN is defined.
interface clk_div_prog_if #(
    parameter int DIV_W = 16
);
    logic             en_i;
    logic [DIV_W-1:0] div_i;
    logic             div_load_i;
    logic             clk_o;
    logic             tick_o;
    logic [DIV_W-1:0] div_o;
    logic             busy_o;
`ifdef CLK_DIV_PROG_RST_OUT_EN
    logic             rst_o;
`endif

    modport slave (
        input  en_i, div_i, div_load_i,
`ifdef CLK_DIV_PROG_RST_OUT_EN
        output rst_o,
`endif
        output clk_o, tick_o, div_o, busy_o
    );

    modport master (
        output en_i, div_i, div_load_i,
`ifdef CLK_DIV_PROG_RST_OUT_EN
        input  rst_o,
`endif
        input  clk_o, tick_o, div_o, busy_o
    );
endinterface

// File: rtl/clk_div_prog.sv
// Run-time programmable clock divider; divisor reloads apply only at a period wrap.
// Define CLK_DIV_PROG_RST_OUT_EN to add a divided-domain reset output (rst_o).
module clk_div_prog #(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 2,
    parameter int RST_CYC = 4
) (
    input  logic           clk_i,
    input  logic           reset,
    clk_div_prog_if.slave  bus
);
    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [DIV_W:0]   half;
    logic [DIV_W-1:0] cnt_n;
    logic             last;

    always_comb begin
        // Extra bit keeps (D+1)>>1 exact for D = 2^DIV_W-1
        half       = ({1'b0, div_act_q} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        last       = (cnt_q == div_act_q - ONE);
        cnt_n      = last ? '0 : cnt_q + ONE;
        cnt_d      = cnt_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        if (bus.en_i) begin
            cnt_d  = cnt_n;
            clk_d  = ({1'b0, cnt_n} < half);
            tick_d = (cnt_n == '0);
            if (last && pend_q) begin
                div_act_d = div_pend_q;
                pend_d    = 1'b0;
            end
        end
        // A load on the wrap edge re-arms pend for the following wrap
        if (bus.div_load_i) begin
            div_pend_d = (bus.div_i < TWO) ? TWO : bus.div_i;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            cnt_q      <= DIV_RST_V - ONE;
            div_act_q  <= DIV_RST_V;
            div_pend_q <= DIV_RST_V;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.clk_o  = clk_q;
    assign bus.tick_o = tick_q;
    assign bus.div_o  = div_act_q;
    assign bus.busy_o = pend_q;

`ifdef CLK_DIV_PROG_RST_OUT_EN
    localparam int TC_W = (RST_CYC < 1) ? 1 : $clog2(RST_CYC + 1);
    localparam logic [TC_W-1:0] TC_MAX = TC_W'(RST_CYC);

    logic [TC_W-1:0] tcnt_q, tcnt_d;
    logic            rst_q, rst_d;

    always_comb begin
        tcnt_d = tcnt_q;
        rst_d  = rst_q;
        if (rst_q && tick_d && (tcnt_q != TC_MAX))
            tcnt_d = tcnt_q + TC_W'(1);
        // Release on a clk_o fall so posedge-clk_o logic sees a clean edge
        if (rst_q && (tcnt_q == TC_MAX) && clk_q && !clk_d)
            rst_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
            rst_q  <= 1'b1;
        end else begin
            tcnt_q <= tcnt_d;
            rst_q  <= rst_d;
        end
    end

    assign bus.rst_o = rst_q;
`endif
endmodule
